// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state type, ASCII constants and default width for the UART echo design.
package uart_pkg;
    localparam int DATA_W_DEF = 8;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_DONE, SEND_LF} echo_state_e;
endpackage

// File: rtl/uart_byte_fifo.sv
// uart_byte_fifo: synchronous FIFO with first-word-fall-through dout; a push on full is legal only alongside a pop.
module uart_byte_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [CW-1:0] count_q;

    always_ff @(posedge clk)
        if (push) mem_q[wr_q] <= din;

    // power-of-two depth lets the pointers wrap naturally
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + AW'(1);
            if (pop) rd_q <= rd_q + AW'(1);
            count_q <= count_q + CW'(push) - CW'(pop);
        end

    assign dout  = mem_q[rd_q];
    assign full  = count_q == CW'(DEPTH);
    assign empty = count_q == '0;
    assign count = count_q;
endmodule

// File: rtl/uart_echo_ctrl.sv
// uart_echo_ctrl: buffers received bytes and replays them through the transmitter start/busy handshake.
// Define UART_ECHO_CRLF_EN to append 0x0A after every echoed 0x0D.
module uart_echo_ctrl
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_W     = DATA_W_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DATA_W-1:0]             rx_data,
    input  logic                          rx_ready,
    output logic [DATA_W-1:0]             tx_data,
    output logic                          tx_start,
    input  logic                          tx_busy,
    output logic                          overflow,
    input  logic                          clr_overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    logic              fifo_full, fifo_empty, push, pop, drop;
    logic [DATA_W-1:0] fifo_dout;
    echo_state_e       state_q;
    logic [DATA_W-1:0] tx_data_q;
    logic              tx_start_q, overflow_q, overflow_d;
`ifdef UART_ECHO_CRLF_EN
    logic              lf_q;
`endif

    uart_byte_fifo #(.DEPTH(FIFO_DEPTH), .W(DATA_W)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (rx_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // a pop frees the slot the same cycle, so a full FIFO can still accept
    assign pop  = state_q == IDLE && !fifo_empty && !tx_busy;
    assign push = rx_ready && (!fifo_full || pop);
    assign drop = rx_ready && !push;

    always_comb overflow_d = drop ? 1'b1 : clr_overflow ? 1'b0 : overflow_q;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) overflow_q <= 1'b0;
        else overflow_q <= overflow_d;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q    <= IDLE;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
`ifdef UART_ECHO_CRLF_EN
            lf_q       <= 1'b0;
`endif
        end else begin
            tx_start_q <= 1'b0;
            case (state_q)
                IDLE:
                    if (pop) begin
                        tx_data_q  <= fifo_dout;
                        tx_start_q <= 1'b1;
                        state_q    <= WAIT_ACK;
`ifdef UART_ECHO_CRLF_EN
                        lf_q       <= fifo_dout == DATA_W'(ASCII_CR);
`endif
                    end
                WAIT_ACK:
                    if (tx_busy) state_q <= WAIT_DONE;
                WAIT_DONE:
`ifdef UART_ECHO_CRLF_EN
                    if (!tx_busy) state_q <= lf_q ? SEND_LF : IDLE;
                SEND_LF: begin
                    tx_data_q  <= DATA_W'(ASCII_LF);
                    tx_start_q <= 1'b1;
                    lf_q       <= 1'b0;
                    state_q    <= WAIT_ACK;
                end
`else
                    if (!tx_busy) state_q <= IDLE;
`endif
                default: state_q <= IDLE;
            endcase
        end

    assign tx_data  = tx_data_q;
    assign tx_start = tx_start_q;
    assign overflow = overflow_q;
endmodule

// File: tb/tb_uart_echo_ctrl.sv
// tb_uart_echo_ctrl: directed and random scoreboard bench for uart_echo_ctrl with a behavioural transmitter.
module tb_uart_echo_ctrl;
    localparam int DEPTH = 4;
`ifdef UART_ECHO_CRLF_EN
    localparam bit CRLF = 1'b1;
`else
    localparam bit CRLF = 1'b0;
`endif

    logic       clk = 1'b0, rst_n = 1'b0, rx_ready = 1'b0, clr_overflow = 1'b0;
    logic [7:0] rx_data = 8'h00, tx_data;
    logic       tx_start, overflow, tx_busy;
    logic [2:0] fifo_count;
    logic       busy_m = 1'b0, hold = 1'b0;
    assign tx_busy = busy_m | hold;

    int checks = 0, failures = 0, start_cnt = 0, tx_len = 100, sc = 0;
    bit rnd = 1'b0;

    logic [7:0] mq[$], log_q[$], exp_b, prev_d;
    bit lf_due, ovf_m, prev_rx, prev_clr, prev_start, popped, drop;
    int occ;

    uart_echo_ctrl #(.FIFO_DEPTH(DEPTH), .DATA_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_data      (rx_data),
        .rx_ready     (rx_ready),
        .tx_data      (tx_data),
        .tx_start     (tx_start),
        .tx_busy      (tx_busy),
        .overflow     (overflow),
        .clr_overflow (clr_overflow),
        .fifo_count   (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // transmitter: busy rises the cycle after start and stays high for a chosen length
    initial forever begin
        @(negedge clk);
        if (tx_start) begin
            @(posedge clk); #1 busy_m = 1'b1;
            repeat (rnd ? $urandom_range(1, 8) : tx_len) @(posedge clk);
            #1 busy_m = 1'b0;
        end
    end

    // scoreboard monitor: expected bytes in arrival order, drops decided by occupancy
    always @(negedge clk) begin
        if (!rst_n) begin
            mq.delete();
            lf_due = 0; ovf_m = 0; prev_rx = 0; prev_clr = 0; prev_start = 0;
        end else begin
            occ = mq.size();
            popped = 0;
            if (tx_start) begin
                start_cnt++;
                log_q.push_back(tx_data);
                chk("start_gap", int'(prev_start), 0);
                chk("start_busy", int'(tx_busy), 0);
                if (lf_due) begin
                    chk("lf_byte", int'(tx_data), 8'h0A);
                    lf_due = 0;
                end else begin
                    chk("pop_nonempty", int'(mq.size() > 0), 1);
                    if (mq.size() > 0) begin
                        exp_b = mq.pop_front();
                        popped = 1;
                        chk("tx_data", int'(tx_data), int'(exp_b));
                        if (CRLF && exp_b == 8'h0D) lf_due = 1;
                    end
                end
            end
            drop = prev_rx && !(occ < DEPTH || popped);
            if (prev_rx && !drop) mq.push_back(prev_d);
            ovf_m = drop ? 1'b1 : prev_clr ? 1'b0 : ovf_m;
            chk("fifo_count", int'(fifo_count), mq.size());
            chk("overflow", int'(overflow), int'(ovf_m));
            prev_rx = rx_ready; prev_d = rx_data; prev_clr = clr_overflow; prev_start = tx_start;
        end
    end

    task automatic drive_rx(input logic [7:0] b);
        @(posedge clk); #1 rx_ready = 1'b1; rx_data = b;
    endtask

    task automatic idle();
        @(posedge clk); #1 rx_ready = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int quiet = 0;
        bit done = 0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            if (mq.size() == 0 && !lf_due && !tx_busy && !tx_start && !prev_rx) quiet++;
            else quiet = 0;
            if (quiet >= 4) done = 1;
        end
        chk("drain_timeout", int'(done), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tx_start", int'(tx_start), 0);
        chk("rst_tx_data", int'(tx_data), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_count", int'(fifo_count), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // single byte latency
        log_q.delete();
        drive_rx(8'h41);
        idle();
        @(negedge clk);
        chk("lat_count_n1", int'(fifo_count), 1);
        chk("lat_start_n1", int'(tx_start), 0);
        @(negedge clk);
        chk("lat_start_n2", int'(tx_start), 1);
        chk("lat_data_n2", int'(tx_data), 8'h41);
        wait_drain(400);
        chk("single_log", int'(log_q.size() == 1 && log_q[0] == 8'h41), 1);
        chk("single_count", int'(fifo_count), 0);

        // three back-to-back bytes
        tx_len = 50; log_q.delete(); sc = start_cnt;
        drive_rx(8'h31); drive_rx(8'h32); drive_rx(8'h33); idle();
        wait_drain(600);
        chk("b2b_starts", start_cnt - sc, 3);
        chk("b2b_order", int'(log_q.size() == 3 && log_q[0] == 8'h31 && log_q[1] == 8'h32 && log_q[2] == 8'h33), 1);

        // overflow while transmitter held busy
        tx_len = 5; log_q.delete();
        @(posedge clk); #1 hold = 1'b1;
        for (int i = 0; i < 6; i++) drive_rx(8'hA0 + 8'(i));
        idle();
        @(negedge clk);
        chk("ovf_count", int'(fifo_count), 4);
        chk("ovf_flag", int'(overflow), 1);
        @(posedge clk); #1 hold = 1'b0;
        wait_drain(400);
        chk("ovf_log", int'(log_q.size() == 4 && log_q[0] == 8'hA0 && log_q[1] == 8'hA1 && log_q[2] == 8'hA2 && log_q[3] == 8'hA3), 1);
        @(posedge clk); #1 clr_overflow = 1'b1;
        @(posedge clk); #1 clr_overflow = 1'b0;
        @(negedge clk);
        chk("ovf_clear", int'(overflow), 0);

        // push on full coinciding with a pop
        log_q.delete();
        @(posedge clk); #1 hold = 1'b1;
        for (int i = 0; i < 4; i++) drive_rx(8'hB0 + 8'(i));
        idle();
        @(posedge clk); #1 hold = 1'b0; rx_ready = 1'b1; rx_data = 8'h99;
        idle();
        @(negedge clk);
        chk("fullpop_ovf", int'(overflow), 0);
        chk("fullpop_count", int'(fifo_count), 4);
        wait_drain(400);
        chk("fullpop_log", int'(log_q.size() == 5 && log_q[0] == 8'hB0 && log_q[4] == 8'h99), 1);

        // carriage return handling
        log_q.delete(); sc = start_cnt;
        drive_rx(8'h0D); drive_rx(8'h58); idle();
        wait_drain(400);
        if (CRLF) chk("crlf_seq", int'(log_q.size() == 3 && log_q[0] == 8'h0D && log_q[1] == 8'h0A && log_q[2] == 8'h58), 1);
        else chk("cr_seq", int'(log_q.size() == 2 && log_q[0] == 8'h0D && log_q[1] == 8'h58), 1);
        chk("cr_starts", start_cnt - sc, CRLF ? 3 : 2);

        // reset during WAIT_DONE with two bytes queued
        tx_len = 30;
        drive_rx(8'h61); drive_rx(8'h62); drive_rx(8'h63); idle();
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_count_pre", int'(fifo_count), 0);
        chk("mid_rst_start", int'(tx_start), 0);
        chk("mid_rst_data", int'(tx_data), 0);
        chk("mid_rst_ovf", int'(overflow), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        sc = start_cnt;
        repeat (100) @(negedge clk);
        chk("post_rst_no_start", start_cnt - sc, 0);
        log_q.delete(); tx_len = 5;
        drive_rx(8'h55); idle();
        wait_drain(400);
        chk("post_rst_byte", int'(log_q.size() == 1 && log_q[0] == 8'h55), 1);

        // random traffic against the scoreboard
        rnd = 1'b1;
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            rx_ready = $urandom_range(0, 2) == 0;
            rx_data = 8'($urandom);
            if ($urandom_range(0, 7) == 0) rx_data = 8'h0D;
            clr_overflow = $urandom_range(0, 15) == 0;
        end
        @(posedge clk); #1 rx_ready = 1'b0; clr_overflow = 1'b0;
        wait_drain(3000);
        rnd = 1'b0;
        chk("final_empty", mq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_echo_ctrl.md
# uart_echo_ctrl

Sequencing controller between the UART receiver and the UART transmitter in the echo design. Captures each byte the receiver reports, buffers it in a small FIFO, and drives the transmitter's start/busy handshake to send the bytes back in order. Reports and latches overflow when the receiver outruns the transmitter.

## Interface
- `FIFO_DEPTH`, default 4: buffer entries; power of two, ≥2.
- `DATA_W`, default 8: byte width.
- `clk`  in  1  system clock; all logic on posedge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `rx_data`  in  DATA_W  received byte; valid only in the `rx_ready` cycle.
- `rx_ready`  in  1  one-cycle pulse; `rx_data` is a new byte.
- `tx_data`  out  DATA_W  byte to transmit; held stable from the `tx_start` pulse until the transmitter finishes.
- `tx_start`  out  1  one-cycle pulse requesting transmission of `tx_data`.
- `tx_busy`  in  1  transmitter busy; rises after `tx_start` and falls when the stop bit completes.
- `overflow`  out  1  sticky flag: a byte was dropped.
- `clr_overflow`  in  1  synchronous clear of `overflow`.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- **Write side:**
  - On `rx_ready`, push `rx_data` if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
  - Otherwise drop the byte and set `overflow`.
  - If `clr_overflow` and a drop occur in the same cycle, `overflow` ends the cycle set (set wins).
- **Read-side FSM** (registered outputs):
  - IDLE: if `fifo_count`≥1 and `tx_busy`=0, pop the head, load `tx_data`, pulse `tx_start`, go to WAIT_ACK.
  - WAIT_ACK: hold until `tx_busy`=1, then go to WAIT_DONE. There is no timeout.
  - WAIT_DONE: hold until `tx_busy`=0, then go to IDLE (or SEND_LF; see Configuration).
  - SEND_LF: load 0x0A, pulse `tx_start`, clear the LF-pending flag, go to WAIT_ACK. This state exists only when the macro is defined.
- `tx_start` is never high for two consecutive cycles.
- `tx_start` is never issued while `tx_busy`=1.
- FIFO pointers wrap modulo `FIFO_DEPTH`. The count goes 0..`FIFO_DEPTH`; a simultaneous push and pop leaves it unchanged.
- A pop on an empty FIFO cannot occur, because the FSM checks `fifo_count`.

## Timing
- Reset values:
  - `tx_data`=0, `tx_start`=0, `overflow`=0, `fifo_count`=0.
  - FSM=IDLE, pointers=0, LF-pending flag=0.
- Reset may be asserted mid-transfer. The FIFO contents and any pending LF are discarded, and the FSM restarts in IDLE.
- After reset releases, the block does not launch a new byte until the transmitter shows `tx_busy`=0.
- Latency when the FIFO is empty and the transmitter is idle: `rx_ready` in cycle N gives `fifo_count`=1 in N+1 and `tx_start`=1 in N+2.
- Back-to-back bytes: the next `tx_start` comes at the earliest 1 cycle after WAIT_DONE sees `tx_busy`=0 (IDLE evaluates, then the pulse is registered).
- `rx_ready` pulses arriving on consecutive cycles are all accepted while space remains.

## Configuration
- `UART_ECHO_CRLF_EN` defined:
  - When a transmitted byte equals 0x0D, the FSM sets LF-pending at pop time.
  - After that byte's WAIT_DONE, the FSM goes to SEND_LF and transmits 0x0A before serving the FIFO again.
  - The inserted LF does not occupy a FIFO slot.
- `UART_ECHO_CRLF_EN` not defined:
  - The SEND_LF state and LF-pending flag are absent.
  - Every byte is echoed verbatim, including 0x0D.

## Structure
- Shared package `uart_pkg` holds:
  - the FSM state enum (IDLE, WAIT_ACK, WAIT_DONE, SEND_LF);
  - constants `ASCII_CR`=8'h0D and `ASCII_LF`=8'h0A;
  - the default data width.
- Sub-module `uart_byte_fifo`: synchronous FIFO (`push`, `pop`, `din`, `dout`, `full`, `empty`, `count`) with first-word-fall-through `dout`.
- `uart_echo_ctrl` instantiates the FIFO and contains the FSM and the overflow logic.

## Test plan
- Single byte 0x41, idle transmitter whose `tx_busy` rises 1 cycle after start and falls 100 cycles later:
  - `tx_start` one pulse at N+2 with `tx_data`=0x41;
  - `fifo_count` returns to 0.
- Bytes 0x31,0x32,0x33 on consecutive cycles, transmitter busy 50 cycles each:
  - echoed in the order 0x31,0x32,0x33;
  - exactly 3 `tx_start` pulses, none while `tx_busy`=1.
- 6 bytes while `tx_busy` is held high (`FIFO_DEPTH`=4):
  - 4 stored, `overflow`=1;
  - after release, exactly the first 4 bytes are echoed;
  - `clr_overflow` pulse gives `overflow`=0.
- FIFO full and `rx_ready` in the same cycle as a pop: the byte is accepted, `overflow` stays 0, count stays 4.
- With `UART_ECHO_CRLF_EN`, input 0x0D,0x58: transmitted sequence 0x0D,0x0A,0x58. Without the macro: 0x0D,0x58.
- `rst_n` pulsed low during WAIT_DONE with 2 bytes queued:
  - all outputs take reset values immediately;
  - no further `tx_start` until a new `rx_ready`.
